// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the machine-mode CSR access controller.
//   - Addresses of the 16 implemented machine-mode CSRs.
//   - CSR instruction op encodings and the controller FSM state type.
//   - Decode helpers: read-only space, implemented-address set, illegal access.
package csr_pkg;

  localparam logic [11:0] CsrMstatus    = 12'h300;
  localparam logic [11:0] CsrMisa       = 12'h301;
  localparam logic [11:0] CsrMie        = 12'h304;
  localparam logic [11:0] CsrMtvec      = 12'h305;
  localparam logic [11:0] CsrMcounteren = 12'h306;
  localparam logic [11:0] CsrMepc       = 12'h341;
  localparam logic [11:0] CsrMcause     = 12'h342;
  localparam logic [11:0] CsrMip        = 12'h344;
  localparam logic [11:0] CsrMcycle     = 12'hB00;
  localparam logic [11:0] CsrMinstret   = 12'hB02;
  localparam logic [11:0] CsrMcycleh    = 12'hB80;
  localparam logic [11:0] CsrMinstreth  = 12'hB82;
  localparam logic [11:0] CsrMvendorid  = 12'hF11;
  localparam logic [11:0] CsrMarchid    = 12'hF12;
  localparam logic [11:0] CsrMimpid     = 12'hF13;
  localparam logic [11:0] CsrMhartid    = 12'hF14;

  typedef enum logic [1:0] {
    OpRw   = 2'b00,
    OpRs   = 2'b01,
    OpRc   = 2'b10,
    OpRsvd = 2'b11  // behaves as OpRw
  } csr_op_e;

  typedef enum logic [3:0] {
    StIdle,
    StRRd,
    StRWt,
    StRWr,
    StRRsp,
    StTEpc,
    StTCau,
    StTVec,
    StTWt
  } csr_state_e;

  // addr[11:10] == 2'b11 is the read-only CSR space; compared as a range so every bit is used.
  function automatic logic csr_is_read_only(input logic [11:0] addr);
    return addr >= 12'hC00;
  endfunction

  function automatic logic csr_is_implemented(input logic [11:0] addr);
    logic hit;
    case (addr)
      CsrMstatus, CsrMisa, CsrMie, CsrMtvec, CsrMcounteren,
      CsrMepc, CsrMcause, CsrMip,
      CsrMcycle, CsrMinstret, CsrMcycleh, CsrMinstreth,
      CsrMvendorid, CsrMarchid, CsrMimpid, CsrMhartid: hit = 1'b1;
      default:                                         hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Unimplemented address, or a plain write (RW or reserved op) to the ID registers.
  function automatic logic csr_is_illegal(input csr_op_e op, input logic [11:0] addr);
    logic id_reg;
    logic is_rw;
    id_reg = (addr >= CsrMvendorid) && (addr <= CsrMhartid);
    is_rw  = (op == OpRw) || (op == OpRsvd);
    return !csr_is_implemented(addr) || (is_rw && id_reg);
  endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// csr_rmw_alu: combinational read-modify-write datapath for CSR instructions.
//   op_i           in   CSR op (RW / RS / RC / reserved-as-RW)
//   old_i          in   current CSR value
//   wdata_i        in   rs1 / immediate operand
//   new_o          out  value to write back
//   write_needed_o out  low when the op cannot change the CSR (RS/RC with a zero mask)
module csr_rmw_alu
  import csr_pkg::*;
(
  input  csr_op_e     op_i,
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] new_o,
  output logic        write_needed_o
);

  always_comb begin
    new_o          = wdata_i;
    write_needed_o = 1'b1;
    unique case (op_i)
      OpRs: begin
        new_o          = old_i | wdata_i;
        write_needed_o = |wdata_i;
      end
      OpRc: begin
        new_o          = old_i & ~wdata_i;
        write_needed_o = |wdata_i;
      end
      default: begin
        new_o          = wdata_i;
        write_needed_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: initiator of the machine-mode CSR register-file port.
// Runs CSRRW/CSRRS/CSRRC as read / (optional) write / respond sequences and sequences trap
// entry (write mepc, write mcause, exception-mode read of mtvec).
//
// Build option: define CSR_ILLEGAL_CHECK_EN to add rsp_illegal_o and reject accesses to
// unimplemented CSRs (and plain writes to the ID registers) without touching the port.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   req_valid_i / req_ready_o    CSR instruction handshake
//   req_op_i, req_addr_i, req_wdata_i   op, CSR address, operand
//   rsp_valid_o, rsp_rdata_o     one-cycle response pulse, old CSR value (held)
//   rsp_illegal_o                illegal-access flag (CSR_ILLEGAL_CHECK_EN only)
//   trap_i, trap_pc_i, trap_cause_i   trap request (level) with pc and cause
//   trap_done_o, trap_vector_o   one-cycle completion pulse, mtvec value
//   csr_address_o, csr_en_write_o, csr_en_read_o, csr_data_o, csr_en_except_o   to register file
//   csr_data_i                   registered read data, valid the cycle after a read strobe
module csr_access_ctrl
  import csr_pkg::*;
#(
  parameter logic [11:0] MEPC_ADDR   = CsrMepc,
  parameter logic [11:0] MCAUSE_ADDR = CsrMcause,
  parameter logic [11:0] MTVEC_ADDR  = CsrMtvec
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [11:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
`ifdef CSR_ILLEGAL_CHECK_EN
  output logic        rsp_illegal_o,
`endif
  input  logic        trap_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_cause_i,
  output logic        trap_done_o,
  output logic [31:0] trap_vector_o,
  output logic [31:0] csr_address_o,
  output logic        csr_en_write_o,
  output logic        csr_en_read_o,
  output logic [31:0] csr_data_o,
  output logic        csr_en_except_o,
  input  logic [31:0] csr_data_i
);

  csr_state_e  state_q, state_d;
  csr_op_e     op_q, op_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] old_q, old_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] trap_vec_q, trap_vec_d;

  // Port outputs are registered: the strobes for a state are loaded on the edge entering it,
  // so they line up with state_q and read data returns in the following state.
  logic [11:0] csr_addr_q, csr_addr_d;
  logic        csr_we_q, csr_we_d;
  logic        csr_re_q, csr_re_d;
  logic [31:0] csr_wdata_q, csr_wdata_d;
  logic        csr_exc_q, csr_exc_d;

`ifdef CSR_ILLEGAL_CHECK_EN
  logic        ill_q, ill_d;
`endif

  logic [31:0] alu_new;
  logic        alu_write_needed;
  logic        write_ok;

  // Old value comes straight from the port: the ALU result is only consumed in StRWt.
  csr_rmw_alu u_rmw_alu (
    .op_i           (op_q),
    .old_i          (csr_data_i),
    .wdata_i        (wdata_q),
    .new_o          (alu_new),
    .write_needed_o (alu_write_needed)
  );

  assign write_ok = alu_write_needed && !csr_is_read_only(addr_q);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    old_d       = old_q;
    cause_d     = cause_q;
    rsp_rdata_d = rsp_rdata_q;
    trap_vec_d  = trap_vec_q;
    csr_addr_d  = '0;
    csr_we_d    = 1'b0;
    csr_re_d    = 1'b0;
    csr_wdata_d = '0;
    csr_exc_d   = 1'b0;
`ifdef CSR_ILLEGAL_CHECK_EN
    ill_d       = ill_q;
`endif

    case (state_q)
      StIdle: begin
        if (trap_i) begin
          // The pc goes straight into the write-data register for the mepc write; only the
          // cause must survive one more cycle.
          cause_d     = trap_cause_i;
          csr_we_d    = 1'b1;
          csr_addr_d  = MEPC_ADDR;
          csr_wdata_d = trap_pc_i;
          state_d     = StTEpc;
        end else if (req_valid_i) begin
          op_d    = csr_op_e'(req_op_i);
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
`ifdef CSR_ILLEGAL_CHECK_EN
          if (csr_is_illegal(csr_op_e'(req_op_i), req_addr_i)) begin
            rsp_rdata_d = '0;
            ill_d       = 1'b1;
            state_d     = StRRsp;
          end else
`endif
          begin
            csr_re_d   = 1'b1;
            csr_addr_d = req_addr_i;
            state_d    = StRRd;
          end
        end
      end

      StRRd: state_d = StRWt;

      StRWt: begin
        old_d = csr_data_i;
        if (write_ok) begin
          csr_we_d    = 1'b1;
          csr_addr_d  = addr_q;
          csr_wdata_d = alu_new;
          state_d     = StRWr;
        end else begin
          rsp_rdata_d = csr_data_i;
`ifdef CSR_ILLEGAL_CHECK_EN
          ill_d       = 1'b0;
`endif
          state_d     = StRRsp;
        end
      end

      StRWr: begin
        rsp_rdata_d = old_q;
`ifdef CSR_ILLEGAL_CHECK_EN
        ill_d       = 1'b0;
`endif
        state_d     = StRRsp;
      end

      StRRsp: state_d = StIdle;

      StTEpc: begin
        csr_we_d    = 1'b1;
        csr_addr_d  = MCAUSE_ADDR;
        csr_wdata_d = cause_q;
        state_d     = StTCau;
      end

      StTCau: begin
        csr_re_d   = 1'b1;
        csr_exc_d  = 1'b1;
        csr_addr_d = MTVEC_ADDR;
        state_d    = StTVec;
      end

      StTVec: state_d = StTWt;

      StTWt: begin
        trap_vec_d = csr_data_i;
        state_d    = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      op_q        <= OpRw;
      addr_q      <= '0;
      wdata_q     <= '0;
      old_q       <= '0;
      cause_q     <= '0;
      rsp_rdata_q <= '0;
      trap_vec_q  <= '0;
      csr_addr_q  <= '0;
      csr_we_q    <= 1'b0;
      csr_re_q    <= 1'b0;
      csr_wdata_q <= '0;
      csr_exc_q   <= 1'b0;
`ifdef CSR_ILLEGAL_CHECK_EN
      ill_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      old_q       <= old_d;
      cause_q     <= cause_d;
      rsp_rdata_q <= rsp_rdata_d;
      trap_vec_q  <= trap_vec_d;
      csr_addr_q  <= csr_addr_d;
      csr_we_q    <= csr_we_d;
      csr_re_q    <= csr_re_d;
      csr_wdata_q <= csr_wdata_d;
      csr_exc_q   <= csr_exc_d;
`ifdef CSR_ILLEGAL_CHECK_EN
      ill_q       <= ill_d;
`endif
    end
  end

  assign req_ready_o     = (state_q == StIdle) && !trap_i;
  assign rsp_valid_o     = (state_q == StRRsp);
  assign rsp_rdata_o     = rsp_rdata_q;
`ifdef CSR_ILLEGAL_CHECK_EN
  assign rsp_illegal_o   = ill_q;
`endif
  assign trap_done_o     = (state_q == StTWt);
  // Live read data during the done pulse, last vector held afterwards.
  assign trap_vector_o   = trap_done_o ? csr_data_i : trap_vec_q;
  assign csr_address_o   = {20'b0, csr_addr_q};
  assign csr_en_write_o  = csr_we_q;
  assign csr_en_read_o   = csr_re_q;
  assign csr_data_o      = csr_wdata_q;
  assign csr_en_except_o = csr_exc_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Scoreboard bench for csr_access_ctrl: the driver pushes every expected port event
// (read strobe, write strobe, response, trap done) with its expected cycle; a monitor pops and
// compares each event the DUT presents. A behavioural register file answers read strobes.
module tb_csr_access_ctrl;

`ifdef CSR_ILLEGAL_CHECK_EN
  localparam bit IllEn = 1'b1;
`else
  localparam bit IllEn = 1'b0;
`endif

  localparam int KRd   = 0;
  localparam int KWr   = 1;
  localparam int KRsp  = 2;
  localparam int KTrap = 3;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_illegal;
  logic        trap;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic        trap_done;
  logic [31:0] trap_vector;
  logic [31:0] csr_address;
  logic        csr_en_write;
  logic        csr_en_read;
  logic [31:0] csr_data_out;
  logic        csr_en_except;
  logic [31:0] csr_data_in;

  csr_access_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_op_i        (req_op),
    .req_addr_i      (req_addr),
    .req_wdata_i     (req_wdata),
    .rsp_valid_o     (rsp_valid),
    .rsp_rdata_o     (rsp_rdata),
`ifdef CSR_ILLEGAL_CHECK_EN
    .rsp_illegal_o   (rsp_illegal),
`endif
    .trap_i          (trap),
    .trap_pc_i       (trap_pc),
    .trap_cause_i    (trap_cause),
    .trap_done_o     (trap_done),
    .trap_vector_o   (trap_vector),
    .csr_address_o   (csr_address),
    .csr_en_write_o  (csr_en_write),
    .csr_en_read_o   (csr_en_read),
    .csr_data_o      (csr_data_out),
    .csr_en_except_o (csr_en_except),
    .csr_data_i      (csr_data_in)
  );

`ifndef CSR_ILLEGAL_CHECK_EN
  assign rsp_illegal = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register-file responder: registered read data one cycle after the strobe.
  logic [31:0] mem [0:4095];
  initial csr_data_in = '0;
  always @(posedge clk) begin
    if (csr_en_read) csr_data_in <= mem[csr_address[11:0]];
  end

  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [31:0] data;
    logic        exc;
    logic        ill;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0b want %0b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [11:0] addr, input logic [31:0] data,
                      input logic exc, input logic ill, input int at);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    e.exc  = exc;
    e.ill  = ill;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  // Monitor: one port event per cycle at most; each is matched against the queue head.
  exp_t mon_e;
  int   mon_kind;
  always @(negedge clk) begin
    if (!rst) begin
      if (csr_en_read || csr_en_write || csr_en_except) begin
        chk1("strobe_exclusive", csr_en_read & csr_en_write, 1'b0);
        chk1("except_needs_read", csr_en_except & ~csr_en_read, 1'b0);
      end
      mon_kind = -1;
      if (csr_en_read)       mon_kind = KRd;
      else if (csr_en_write) mon_kind = KWr;
      else if (rsp_valid)    mon_kind = KRsp;
      else if (trap_done)    mon_kind = KTrap;
      if (mon_kind >= 0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got kind %0d want none (cycle %0d)", mon_kind, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("event_kind", mon_kind, mon_e.kind);
          chk("event_cycle", cyc, mon_e.cyc);
          case (mon_e.kind)
            KRd: begin
              chk("rd_addr", csr_address, {20'b0, mon_e.addr});
              chk1("rd_except", csr_en_except, mon_e.exc);
            end
            KWr: begin
              chk("wr_addr", csr_address, {20'b0, mon_e.addr});
              chk("wr_data", csr_data_out, mon_e.data);
            end
            KRsp: begin
              chk("rsp_rdata", rsp_rdata, mon_e.data);
              if (IllEn) chk1("rsp_illegal", rsp_illegal, mon_e.ill);
            end
            default: chk("trap_vector", trap_vector, mon_e.data);
          endcase
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s: timeout with %0d events pending, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [31:0] old;
    bit          wr;    // write strobe expected (legal build)
    logic [31:0] newv;
    bit          ill;   // illegal when the check is built in
  } vec_t;

  vec_t vecs [0:10];

  task automatic issue(input vec_t v, output logic [31:0] rsp_exp);
    int k;
    @(negedge clk);
    chk1("ready_idle", req_ready, 1'b1);
    mem[v.addr] = v.old;
    k = cyc + 1;
    req_valid = 1'b1;
    req_op    = v.op;
    req_addr  = v.addr;
    req_wdata = v.wd;
    if (IllEn && v.ill) begin
      push(KRsp, v.addr, 32'h0, 1'b0, 1'b1, k);
      rsp_exp = 32'h0;
    end else begin
      push(KRd, v.addr, 32'h0, 1'b0, 1'b0, k);
      if (v.wr) begin
        push(KWr, v.addr, v.newv, 1'b0, 1'b0, k + 2);
        push(KRsp, v.addr, v.old, 1'b0, 1'b0, k + 3);
      end else begin
        push(KRsp, v.addr, v.old, 1'b0, 1'b0, k + 2);
      end
      rsp_exp = v.old;
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = 32'hFFFF_FFFF;  // operand must have been captured
    req_addr  = 12'hABC;
  endtask

  logic [31:0] rsp_exp;
  int          k;
  int          kt;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{2'b00, 12'h305, 32'h0000_1000, 32'h0000_0000, 1'b1, 32'h0000_1000, 1'b0};
    vecs[1]  = '{2'b01, 12'h300, 32'h0000_0008, 32'h0000_0001, 1'b1, 32'h0000_0009, 1'b0};
    vecs[2]  = '{2'b10, 12'h304, 32'h0000_0003, 32'h0000_000F, 1'b1, 32'h0000_000C, 1'b0};
    vecs[3]  = '{2'b01, 12'h300, 32'h0000_0000, 32'h0000_0009, 1'b0, 32'h0000_0000, 1'b0};
    vecs[4]  = '{2'b11, 12'h341, 32'h0000_0055, 32'h0000_0007, 1'b1, 32'h0000_0055, 1'b0};
    vecs[5]  = '{2'b10, 12'h344, 32'h0000_0000, 32'h0000_FFFF, 1'b0, 32'h0000_0000, 1'b0};
    vecs[6]  = '{2'b00, 12'hF11, 32'h0000_1234, 32'h0000_ABCD, 1'b0, 32'h0000_0000, 1'b1};
    vecs[7]  = '{2'b01, 12'hF12, 32'h0000_0001, 32'h0000_0005, 1'b0, 32'h0000_0000, 1'b0};
    vecs[8]  = '{2'b00, 12'h7C0, 32'h0000_DEAD, 32'h0000_0022, 1'b1, 32'h0000_DEAD, 1'b1};
    vecs[9]  = '{2'b00, 12'hC00, 32'h0000_0001, 32'h0000_0003, 1'b0, 32'h0000_0000, 1'b1};
    vecs[10] = '{2'b10, 12'h300, 32'hFFFF_FFFF, 32'hFFFF_0001, 1'b1, 32'h0000_0000, 1'b0};

    rst = 1'b1;
    req_valid = 1'b0;
    req_op = 2'b00;
    req_addr = '0;
    req_wdata = '0;
    trap = 1'b0;
    trap_pc = '0;
    trap_cause = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk1("rst_ready", req_ready, 1'b1);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_trap_done", trap_done, 1'b0);
    chk1("rst_wr", csr_en_write, 1'b0);
    chk1("rst_rd", csr_en_read, 1'b0);
    chk1("rst_except", csr_en_except, 1'b0);
    chk("rst_addr", csr_address, 32'h0);
    chk("rst_data", csr_data_out, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_vector", trap_vector, 32'h0);
    if (IllEn) chk1("rst_illegal", rsp_illegal, 1'b0);
    rst = 1'b0;

    // Directed request vectors
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i], rsp_exp);
      wait_drain("vec_drain");
      @(negedge clk);
      chk("rsp_hold", rsp_rdata, rsp_exp);
    end

    // Trap and request in the same cycle: trap wins, request follows.
    @(negedge clk);
    chk1("ready_pre_trap", req_ready, 1'b1);
    mem[12'h305] = 32'h0000_0100;
    mem[12'h300] = 32'h0000_0009;
    kt = cyc + 1;
    trap       = 1'b1;
    trap_pc    = 32'h0000_0040;
    trap_cause = 32'h0000_0002;
    req_valid  = 1'b1;
    req_op     = 2'b01;
    req_addr   = 12'h300;
    req_wdata  = 32'h0000_0010;
    push(KWr, 12'h341, 32'h0000_0040, 1'b0, 1'b0, kt);
    push(KWr, 12'h342, 32'h0000_0002, 1'b0, 1'b0, kt + 1);
    push(KRd, 12'h305, 32'h0, 1'b1, 1'b0, kt + 2);
    push(KTrap, 12'h0, 32'h0000_0100, 1'b0, 1'b0, kt + 3);
    push(KRd, 12'h300, 32'h0, 1'b0, 1'b0, kt + 5);
    push(KWr, 12'h300, 32'h0000_0019, 1'b0, 1'b0, kt + 7);
    push(KRsp, 12'h300, 32'h0000_0009, 1'b0, 1'b0, kt + 8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cyc < kt + 4) chk1("ready_during_trap", req_ready, 1'b0);
      if (cyc == kt) begin
        trap_pc    = 32'hFFFF_FFFF;
        trap_cause = 32'hFFFF_FFFF;
      end
      if (cyc == kt + 3) trap = 1'b0;
      if (cyc == kt + 4) chk1("ready_after_trap", req_ready, 1'b1);
      if (cyc == kt + 5) begin
        req_valid = 1'b0;
        break;
      end
    end
    wait_drain("trap_drain");
    @(negedge clk);
    chk("vector_hold", trap_vector, 32'h0000_0100);

    // Trap raised during a request waits for the response.
    @(negedge clk);
    chk1("ready_pre_midtrap", req_ready, 1'b1);
    mem[12'h342] = 32'h0000_0002;
    k = cyc + 1;
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_addr  = 12'h342;
    req_wdata = 32'h0000_0003;
    push(KRd, 12'h342, 32'h0, 1'b0, 1'b0, k);
    push(KWr, 12'h342, 32'h0000_0003, 1'b0, 1'b0, k + 2);
    push(KRsp, 12'h342, 32'h0000_0002, 1'b0, 1'b0, k + 3);
    kt = k + 5;
    push(KWr, 12'h341, 32'h0000_0080, 1'b0, 1'b0, kt);
    push(KWr, 12'h342, 32'h0000_0007, 1'b0, 1'b0, kt + 1);
    push(KRd, 12'h305, 32'h0, 1'b1, 1'b0, kt + 2);
    push(KTrap, 12'h0, 32'h0000_0100, 1'b0, 1'b0, kt + 3);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cyc == k) begin
        req_valid  = 1'b0;
        trap       = 1'b1;
        trap_pc    = 32'h0000_0080;
        trap_cause = 32'h0000_0007;
      end
      if (cyc == kt) begin
        trap_pc    = 32'h1234_5678;
        trap_cause = 32'h8765_4321;
      end
      if (cyc == kt + 3) begin
        trap = 1'b0;
        break;
      end
    end
    wait_drain("midtrap_drain");

    // Reset while the write strobe is up.
    @(negedge clk);
    chk1("ready_pre_rst", req_ready, 1'b1);
    mem[12'h301] = 32'h0000_0001;
    k = cyc + 1;
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_addr  = 12'h301;
    req_wdata = 32'h0000_0077;
    push(KRd, 12'h301, 32'h0, 1'b0, 1'b0, k);
    push(KWr, 12'h301, 32'h0000_0077, 1'b0, 1'b0, k + 2);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk1("wr_before_rst", csr_en_write, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk1("wr_after_rst", csr_en_write, 1'b0);
    chk1("ready_in_rst", req_ready, 1'b1);
    chk1("rsp_in_rst", rsp_valid, 1'b0);
    chk("addr_in_rst", csr_address, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1("no_rsp_after_rst", rsp_valid, 1'b0);
    end
    chk("queue_after_rst", exp_q.size(), 32'd0);

    // Recovery after reset
    issue(vecs[2], rsp_exp);
    wait_drain("recovery_drain");
    @(negedge clk);
    chk("rsp_hold_recovery", rsp_rdata, rsp_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
